// File: rtl/rr_packet_merge_2_pkg.sv
// rr_merge_pkg: shared arbitration state, source index type and helpers for rr_packet_merge_2
package rr_merge_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} arb_state_t;
    typedef logic src_t;
    localparam src_t SRC0 = 1'b0;
    localparam src_t SRC1 = 1'b1;
    function automatic arb_state_t lock_of(src_t s);
        return s ? ST_LOCK1 : ST_LOCK0;
    endfunction
endpackage

// File: rtl/rr_packet_merge_2_if.sv
// rr_packet_merge_2_if: two upstream packet streams and one downstream stream with source tag
interface rr_packet_merge_2_if #(parameter int WIDTH = 8);
    import rr_merge_pkg::*;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    src_t             out_src;
    modport master (
        output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_last, out_src
    );
    modport slave (
        input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/rr_packet_merge_2_stream_out_reg.sv
// stream_out_reg: one-entry registered output stage; refills in the same cycle it drains
module stream_out_reg
    import rr_merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  src_t             in_src,
    input  logic             out_ready,
    output logic             load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output src_t             out_src
);
    logic             valid_q, valid_d;
    logic [WIDTH+1:0] beat_q, beat_d;
    always_comb begin
        load    = !valid_q || out_ready;
        valid_d = load ? in_valid : valid_q;
        beat_d  = (load && in_valid) ? {in_src, in_last, in_data} : beat_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end
    assign out_valid                     = valid_q;
    assign {out_src, out_last, out_data} = beat_q;
endmodule

// File: rtl/rr_packet_merge_2.sv
// rr_packet_merge_2: round-robin merge of two packet streams, packets locked to a source until last
module rr_packet_merge_2
    import rr_merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_packet_merge_2_if.slave bus
);
    arb_state_t       state_q, state_d;
    src_t             rr_ptr_q, rr_ptr_d;
    src_t             sel;
    logic             sel_en, load, xfer, xlast;
    logic [WIDTH-1:0] xdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= SRC0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            state_d  = xlast ? ST_IDLE : lock_of(sel);
            rr_ptr_d = xlast ? src_t'(~sel) : rr_ptr_q;
        end
    end
    // A locked source keeps its grant even while idle, so the other side sees bubbles
    always_comb begin
        sel = (state_q == ST_LOCK1) ? SRC1 :
              (state_q == ST_LOCK0) ? SRC0 :
              (bus.in0_valid && bus.in1_valid) ? rr_ptr_q : src_t'(bus.in1_valid);
        sel_en        = (state_q != ST_IDLE) || bus.in0_valid || bus.in1_valid;
        bus.in0_ready = load && sel_en && (sel == SRC0);
        bus.in1_ready = load && sel_en && (sel == SRC1);
        xfer          = sel ? (bus.in1_valid && bus.in1_ready) : (bus.in0_valid && bus.in0_ready);
        xlast         = sel ? bus.in1_last : bus.in0_last;
        xdata         = sel ? bus.in1_data : bus.in0_data;
    end
    stream_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_valid (xfer),
        .in_data  (xdata),
        .in_last  (xlast),
        .in_src   (sel),
        .out_ready(bus.out_ready),
        .load     (load),
        .out_valid(bus.out_valid),
        .out_data (bus.out_data),
        .out_last (bus.out_last),
        .out_src  (bus.out_src)
    );
endmodule

// File: tb/tb_rr_packet_merge_2.sv
// tb_rr_packet_merge_2: directed and random stimulus against a packet-level reference model
module tb_rr_packet_merge_2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rr_packet_merge_2_if #(.WIDTH(8)) bus ();
    rr_packet_merge_2 #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int checks = 0;
    int failures = 0;
    int owner = -1;
    int pref = 0;
    logic m_v = 1'b0, m_l = 1'b0, m_s = 1'b0;
    logic [7:0] m_d = 8'h00;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cycle(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
        logic ld, xv;
        int cand;
        rst = r;
        bus.in0_valid = v0; bus.in0_data = d0; bus.in0_last = l0;
        bus.in1_valid = v1; bus.in1_data = d1; bus.in1_last = l1;
        bus.out_ready = ordy;
        #2;
        ld = !m_v || ordy;
        cand = -1;
        if (owner >= 0) cand = owner;
        else if (v0 && v1) cand = pref;
        else if (v0) cand = 0;
        else if (v1) cand = 1;
        chk("in0_ready", bus.in0_ready, ld && cand == 0);
        chk("in1_ready", bus.in1_ready, ld && cand == 1);
        xv = ld && cand >= 0 && (cand == 0 ? v0 : v1);
        @(posedge clk);
        #1;
        if (r) begin
            owner = -1; pref = 0; m_v = 0; m_d = 0; m_l = 0; m_s = 0;
        end else begin
            if (ld) begin
                m_v = xv;
                if (xv) begin
                    m_d = cand == 0 ? d0 : d1;
                    m_l = cand == 0 ? l0 : l1;
                    m_s = cand[0];
                end
            end
            if (xv) begin
                if ((cand == 0) ? l0 : l1) begin
                    owner = -1;
                    pref = 1 - cand;
                end else owner = cand;
            end
        end
        chk("out_valid", bus.out_valid, m_v);
        chk("out_data", bus.out_data, m_d);
        chk("out_last", bus.out_last, m_l);
        chk("out_src", bus.out_src, m_s);
    endtask
    task automatic beat(input logic v0, input logic v1, input logic ordy);
        cycle(1'b0, v0, 8'($urandom), 1'b1, v1, 8'($urandom), 1'b1, ordy);
    endtask
    task automatic do_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask
    int reqs [10] = '{1, 0, 2, 3, 3, 0, 3, 0, 3, 3};
    int srcs [10] = '{0, -1, 1, 0, 1, -1, 0, -1, 1, 0};
    initial begin
        do_reset();
        do_reset();
        chk("reset_out_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 1'b1, 1'b1);
            chk("alt_src", bus.out_src, i % 2);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            beat(reqs[i][0], reqs[i][1], 1'b1);
            chk("seq_valid", bus.out_valid, srcs[i] >= 0);
            if (srcs[i] >= 0) chk("seq_src", bus.out_src, srcs[i]);
        end
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(i + 1), i == 2, 1'b1, 8'h77, 1'b1, 1'b1);
        beat(1'b0, 1'b1, 1'b1);
        chk("after_lock_src", bus.out_src, 1'b1);
        do_reset();
        cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        chk("gap_valid", bus.out_valid, 1'b0);
        cycle(1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        chk("gap_then_src1", bus.out_src, 1'b1);
        do_reset();
        cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("bp_hold", bus.out_data, 8'hA5);
        cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
        chk("bp_release", bus.out_data, 8'h5A);
        do_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        chk("rst_lock_valid", bus.out_valid, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        chk("rst_lock_src0", bus.out_src, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 1'b1, 1'b1);
            chk("single_src1", bus.out_valid && bus.out_src, 1'b1);
        end
        beat(1'b1, 1'b1, 1'b1);
        chk("single_then_src0", bus.out_src, 1'b0);
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 99) == 0, 1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0,
                  1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
